// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared FSM state type and default datapath width for add_arbiter.
package add_arb_pkg;
  typedef enum logic {IDLE, EXEC} state_t;
  localparam int ADD_W = 16;
endpackage

// File: rtl/add_arbiter_if.sv
// add_arbiter_if: request/grant/result bundle between the requesting units and the adder arbiter.
interface add_arbiter_if import add_arb_pkg::*; #(parameter int N = 4, parameter int W = ADD_W);
  logic [N-1:0] req;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic [W-1:0] result;
  logic busy;
  modport master(output req, op_a, op_b, input gnt, done, result, busy);
  modport slave(input req, op_a, op_b, output gnt, done, result, busy);
endinterface

// File: rtl/add.sv
// add: the shared combinational adder; the sum wraps modulo 2^W with no carry out.
module add #(parameter int W = 16) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter sharing one add instance between N requesters;
// grant cycle latches operands, next edge registers the sum and pulses done to the winner.
module add_arbiter import add_arb_pkg::*; #(parameter int N = 4, parameter int W = ADD_W) (
  input logic clk,
  input logic rst_n,
  add_arbiter_if.slave bus
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  state_t state;
  logic [PW-1:0] ptr, win;
  logic [N-1:0] sel;
  logic [W-1:0] a, b, sum;
  // Scan from farthest to nearest so the first requester at or after p wins.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
    int idx;
    rr_pick = p;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % N;
      if (r[idx]) rr_pick = PW'(idx);
    end
  endfunction
  assign win = rr_pick(bus.req, ptr);
  always_comb begin
    sel = '0;
    sel[win] = 1'b1;
  end
  add #(.W(W)) u_add (.a(a), .b(b), .y(sum));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.gnt <= '0;
      bus.done <= '0;
      bus.result <= '0;
      bus.busy <= 1'b0;
      ptr <= '0;
      a <= '0;
      b <= '0;
    end else if (state == IDLE) begin
      bus.done <= '0;
      if (|bus.req) begin
        state <= EXEC;
        bus.gnt <= sel;
        bus.busy <= 1'b1;
        a <= bus.op_a[int'(win)*W +: W];
        b <= bus.op_b[int'(win)*W +: W];
        ptr <= win == PW'(N - 1) ? '0 : win + PW'(1);
      end
    end else begin
      state <= IDLE;
      bus.result <= sum;
      bus.done <= bus.gnt;
      bus.gnt <= '0;
      bus.busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: vector table, hand-written corner sequences and a randomized
// transaction-level round-robin model for add_arbiter.
module tb_add_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [N-1:0] gnt;
    logic [W-1:0] res;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t tbl[7];
  logic [N-1:0] r;
  logic [W-1:0] ra[N];
  logic [W-1:0] rb[N];
  logic [W-1:0] last_res;
  int ptr_m, win;
  add_arbiter_if #(.N(N), .W(W)) bus();
  add_arbiter #(.N(N), .W(W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < N; i++) begin
      bus.op_a[i*W +: W] = a + W'(i);
      bus.op_b[i*W +: W] = b;
    end
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    bus.req = '0;
    set_ops('0, '0);
    step;
    step;
    @(negedge clk);
    rst_n = 1'b1;
    step;
  endtask
  initial begin
    bus.req = '0;
    set_ops('0, '0);
    tbl[0] = '{4'b0001, 16'd10, 16'd10, 4'b0001, 16'd20};
    tbl[1] = '{4'b1111, 16'd0, 16'd100, 4'b0010, 16'd101};
    tbl[2] = '{4'b1111, 16'd0, 16'd100, 4'b0100, 16'd102};
    tbl[3] = '{4'b0101, 16'd2, 16'd10, 4'b0001, 16'd12};
    tbl[4] = '{4'b0101, 16'hFFFD, 16'h0001, 4'b0100, 16'h0000};
    tbl[5] = '{4'b1000, 16'd5, 16'd5, 4'b1000, 16'd13};
    tbl[6] = '{4'b1111, 16'd0, 16'd100, 4'b0001, 16'd100};
    do_reset;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.result, 0);
    // Vector table: operands are corrupted during EXEC to prove the latch.
    for (int t = 0; t < 7; t++) begin
      bus.req = tbl[t].req;
      set_ops(tbl[t].a, tbl[t].b);
      step;
      chk("tbl_gnt", bus.gnt, tbl[t].gnt);
      chk("tbl_busy", bus.busy, 1);
      chk("tbl_done_low", bus.done, 0);
      bus.req = '0;
      set_ops(~tbl[t].a, 16'h1234);
      step;
      chk("tbl_done", bus.done, tbl[t].gnt);
      chk("tbl_result", bus.result, tbl[t].res);
      chk("tbl_gnt_low", bus.gnt, 0);
      chk("tbl_busy_low", bus.busy, 0);
    end
    step;
    chk("idle_done_low", bus.done, 0);
    chk("idle_result_hold", bus.result, 16'd100);
    // All requesters held high: strict rotation 0,1,2,3,0.
    do_reset;
    bus.req = 4'b1111;
    set_ops(16'd0, 16'd100);
    for (int k = 0; k < 5; k++) begin
      step;
      chk("all_gnt", bus.gnt, 32'(1) << (k % N));
      step;
      chk("all_done", bus.done, 32'(1) << (k % N));
      chk("all_result", bus.result, 100 + (k % N));
    end
    // Reset during EXEC aborts and returns the pointer to 0.
    do_reset;
    bus.req = 4'b0001;
    set_ops(16'd7, 16'd8);
    step;
    bus.req = '0;
    step;
    chk("pre_rst_result", bus.result, 16'd15);
    bus.req = 4'b0010;
    step;
    chk("pre_rst_gnt", bus.gnt, 4'b0010);
    #1 rst_n = 1'b0;
    bus.req = '0;
    #1;
    chk("async_gnt", bus.gnt, 0);
    chk("async_busy", bus.busy, 0);
    chk("async_done", bus.done, 0);
    chk("async_result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step;
    chk("post_rst_done", bus.done, 0);
    step;
    chk("post_rst_done2", bus.done, 0);
    bus.req = 4'b0110;
    step;
    chk("post_rst_gnt", bus.gnt, 4'b0010);
    bus.req = '0;
    step;
    chk("post_rst_res", bus.result, 16'd16);
    // Randomized transactions against a round-robin model.
    do_reset;
    ptr_m = 0;
    last_res = '0;
    for (int it = 0; it < 300; it++) begin
      r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      for (int i = 0; i < N; i++) begin
        ra[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
        rb[i] = W'($urandom);
        bus.op_a[i*W +: W] = ra[i];
        bus.op_b[i*W +: W] = rb[i];
      end
      bus.req = r;
      step;
      if (r == '0) begin
        chk("rnd_idle_gnt", bus.gnt, 0);
        chk("rnd_idle_busy", bus.busy, 0);
        chk("rnd_idle_done", bus.done, 0);
        chk("rnd_idle_result", bus.result, last_res);
      end else begin
        win = -1;
        for (int k = 0; k < N; k++)
          if (win < 0 && r[(ptr_m + k) % N]) win = (ptr_m + k) % N;
        ptr_m = (win + 1) % N;
        last_res = ra[win] + rb[win];
        chk("rnd_gnt", bus.gnt, 32'(1) << win);
        chk("rnd_busy", bus.busy, 1);
        chk("rnd_done_low", bus.done, 0);
        bus.req = N'($urandom);
        bus.op_a = {N{W'($urandom)}};
        bus.op_b = {N{W'($urandom)}};
        step;
        chk("rnd_done", bus.done, 32'(1) << win);
        chk("rnd_result", bus.result, last_res);
        chk("rnd_gnt_low", bus.gnt, 0);
        chk("rnd_busy_low", bus.busy, 0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
